// File: rtl/uart_byte_fifo.sv
// Byte FIFO between uart_rx and uart_tx: four-phase RX handshake in, one tx_start per byte out.
// Define UART_FIFO_OVF_EN for drop mode (ack-and-discard when full, sticky overflow flag).
module uart_byte_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rxdata,
   input  logic                  rxvalid,
   output logic                  rxack,
   output logic [7:0]            txdata,
   output logic                  tx_start,
   input  logic                  tx_busy,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow,
   input  logic                  ovf_clr
);

   localparam int                 DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic {R_IDLE, R_ACK} rx_state_e;
   typedef enum logic [1:0] {T_IDLE, T_START, T_WAIT_BUSY, T_WAIT_DONE} tx_state_e;

   rx_state_e               rx_state_q;
   tx_state_e               tx_state_q;
   logic [7:0]              mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG2:0]     count_q, count_d;
   logic                    empty_q, full_q;
   logic                    rxack_q, tx_start_q;
   logic [7:0]              txdata_q;
   logic                    push, pop, rx_take;

   // Push acceptance looks only at the registered full flag, so a same-cycle pop never frees a slot early.
   assign push = (rx_state_q == R_IDLE) && rxvalid && !full_q;
   assign pop  = (tx_state_q == T_IDLE) && !empty_q;

`ifdef UART_FIFO_OVF_EN
   logic drop, overflow_q;

   assign drop    = (rx_state_q == R_IDLE) && rxvalid && full_q;
   assign rx_take = push | drop;

   // A drop in the same cycle as ovf_clr leaves the flag set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_q <= 1'b0;
      end else if (drop) begin
         overflow_q <= 1'b1;
      end else if (ovf_clr) begin
         overflow_q <= 1'b0;
      end
   end

   assign overflow = overflow_q;
`else
   logic unused_ovf_clr;

   assign rx_take        = push;
   assign overflow       = 1'b0;
   assign unused_ovf_clr = ovf_clr;
`endif

   // NOTE: every variable driven in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         wr_ptr_q <= '0;
      end else begin
         count_q <= count_d;
         empty_q <= (count_d == '0);
         full_q  <= (count_d == DEPTH_CNT);
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
      end
   end

   // NOTE: storage has no reset; only pointers and count define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= rxdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_state_q <= R_IDLE;
         rxack_q    <= 1'b0;
      end else begin
         case (rx_state_q)
            R_IDLE: begin
               if (rx_take) begin
                  rx_state_q <= R_ACK;
                  rxack_q    <= 1'b1;
               end
            end
            R_ACK: begin
               if (!rxvalid) begin
                  rx_state_q <= R_IDLE;
                  rxack_q    <= 1'b0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state_q <= T_IDLE;
         tx_start_q <= 1'b0;
         txdata_q   <= 8'h00;
         rd_ptr_q   <= '0;
      end else begin
         case (tx_state_q)
            T_IDLE: begin
               if (pop) begin
                  txdata_q   <= mem_q[rd_ptr_q];
                  rd_ptr_q   <= rd_ptr_q + 1'b1;
                  tx_start_q <= 1'b1;
                  tx_state_q <= T_START;
               end
            end
            T_START: begin
               tx_start_q <= 1'b0;
               tx_state_q <= T_WAIT_BUSY;
            end
            T_WAIT_BUSY: begin
               if (tx_busy) begin
                  tx_state_q <= T_WAIT_DONE;
               end
            end
            T_WAIT_DONE: begin
               if (!tx_busy) begin
                  tx_state_q <= T_IDLE;
               end
            end
         endcase
      end
   end

   assign rxack    = rxack_q;
   assign tx_start = tx_start_q;
   assign txdata   = txdata_q;
   assign count    = count_q;
   assign empty    = empty_q;
   assign full     = full_q;

endmodule
